// File: rtl/control_unit_pkg.sv
// Shared definitions for the hardwired control unit: step encodings, opcode constants,
// the control-word layout and the instruction-class decoder.
package control_unit_pkg;

  localparam int OPW = 5;

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [OPW-1:0] OP_LD   = 5'b00000;
  localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OP_ST   = 5'b00010;
  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_AND  = 5'b00101;
  localparam logic [OPW-1:0] OP_OR   = 5'b00110;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
  localparam logic [OPW-1:0] OP_SHRA = 5'b01000;
  localparam logic [OPW-1:0] OP_SHL  = 5'b01001;
  localparam logic [OPW-1:0] OP_ROR  = 5'b01010;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01011;
  localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
  localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
  localparam logic [OPW-1:0] OP_ORI  = 5'b01110;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPW-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    C_ALU, C_IMM, C_MULDIV, C_UNARY, C_LD, C_LDI, C_ST, C_NOP, C_HALT
  } iclass_t;

  typedef struct packed {
    logic pcout, zhighout, zlowout, mdrout, hiout, loout, cout;
    logic marin, zin, pcin, mdrin, irin, yin, hiin, loin;
    logic incpc, read, write, gra, grb, grc, rin, rout, baout;
    logic [OPW-1:0] opcode;
  } ctrl_t;

  // Unlisted opcodes fall into C_NOP so they simply refetch.
  function automatic iclass_t decode_class(input logic [OPW-1:0] op);
    if (op inside {[OP_ADD:OP_ROL]}) return C_ALU;
    case (op)
      OP_LD:                   return C_LD;
      OP_LDI:                  return C_LDI;
      OP_ST:                   return C_ST;
      OP_ADDI, OP_ANDI, OP_ORI: return C_IMM;
      OP_MUL, OP_DIV:          return C_MULDIV;
      OP_NEG, OP_NOT:          return C_UNARY;
      OP_HALT:                 return C_HALT;
      default:                 return C_NOP;
    endcase
  endfunction

  function automatic logic [OPW-1:0] imm_alu_op(input logic [OPW-1:0] op);
    case (op)
      OP_ANDI: return OP_AND;
      OP_ORI:  return OP_OR;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit to datapath link: instruction register in, per-step strobes and ALU opcode out.
interface control_unit_if;
  logic [31:0] IR;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin;
  logic IncPC, Read, Write;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic [control_unit_pkg::OPW-1:0] opcode;
  logic Run;

  modport master (
    input  IR,
    output PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout,
    output MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
    output IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, opcode, Run
  );

  modport slave (
    output IR,
    input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout,
    input  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
    input  IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, opcode, Run
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired control FSM: fetch T0-T2, then execute steps chosen by IR[31:27].
// Strobes are a Moore decode of the step register, forced low while clear is high.
module control_unit
  import control_unit_pkg::*;
(
  input  logic           Clock,
  input  logic           clear,
  control_unit_if.master cu
);

  state_t          r_state;
  iclass_t         w_class;
  ctrl_t           w_ctrl;
  logic [OPW-1:0]  w_op;
  logic            w_unused_ir;

  assign w_op        = cu.IR[31:27];
  assign w_class     = decode_class(w_op);
  assign w_unused_ir = ^cu.IR[26:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (clear) begin
      r_state <= S_T0;
    end else begin
      case (r_state)
        S_T0: r_state <= S_T1;
        S_T1: r_state <= S_T2;
        S_T2: begin
          case (w_class)
            C_HALT:  r_state <= S_HALT;
            C_NOP:   r_state <= S_T0;
            default: r_state <= S_T3;
          endcase
        end
        S_T3: r_state <= S_T4;
        S_T4: r_state <= (w_class == C_UNARY) ? S_T0 : S_T5;
        S_T5: r_state <= (w_class inside {C_ALU, C_IMM, C_LDI}) ? S_T0 : S_T6;
        S_T6: r_state <= (w_class == C_MULDIV) ? S_T0 : S_T7;
        S_T7: r_state <= S_T0;
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_T0;
      endcase
    end
  end

  always_comb begin
    // NOTE: zeroing the whole control word first keeps every path assigned, so no latches appear.
    w_ctrl = '0;
    case (r_state)
      S_T0: begin
        w_ctrl.pcout = 1'b1; w_ctrl.marin = 1'b1; w_ctrl.incpc = 1'b1; w_ctrl.zin = 1'b1;
      end
      S_T1: begin
        w_ctrl.zlowout = 1'b1; w_ctrl.pcin = 1'b1; w_ctrl.read = 1'b1; w_ctrl.mdrin = 1'b1;
      end
      S_T2: begin
        w_ctrl.mdrout = 1'b1; w_ctrl.irin = 1'b1;
      end
      S_T3: begin
        case (w_class)
          C_ALU, C_IMM: begin w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.yin = 1'b1; end
          C_MULDIV:     begin w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.yin = 1'b1; end
          C_UNARY: begin
            w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.zin = 1'b1; w_ctrl.opcode = w_op;
          end
          C_LD, C_LDI, C_ST: begin w_ctrl.grb = 1'b1; w_ctrl.baout = 1'b1; w_ctrl.yin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (w_class)
          C_ALU: begin
            w_ctrl.grc = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.zin = 1'b1; w_ctrl.opcode = w_op;
          end
          C_MULDIV: begin
            w_ctrl.grb = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.zin = 1'b1; w_ctrl.opcode = w_op;
          end
          C_IMM: begin w_ctrl.cout = 1'b1; w_ctrl.zin = 1'b1; w_ctrl.opcode = imm_alu_op(w_op); end
          C_UNARY: begin w_ctrl.zlowout = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1; end
          C_LD, C_LDI, C_ST: begin w_ctrl.cout = 1'b1; w_ctrl.zin = 1'b1; w_ctrl.opcode = OP_ADD; end
          default: ;
        endcase
      end
      S_T5: begin
        w_ctrl.zlowout = 1'b1;
        case (w_class)
          C_ALU, C_IMM, C_LDI: begin w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1; end
          C_MULDIV:            w_ctrl.loin = 1'b1;
          C_LD, C_ST:          w_ctrl.marin = 1'b1;
          default:             w_ctrl.zlowout = 1'b0;
        endcase
      end
      S_T6: begin
        case (w_class)
          C_MULDIV: begin w_ctrl.zhighout = 1'b1; w_ctrl.hiin = 1'b1; end
          C_LD:     begin w_ctrl.read = 1'b1; w_ctrl.mdrin = 1'b1; end
          C_ST:     begin w_ctrl.gra = 1'b1; w_ctrl.rout = 1'b1; w_ctrl.mdrin = 1'b1; end
          default: ;
        endcase
      end
      S_T7: begin
        case (w_class)
          C_LD:    begin w_ctrl.mdrout = 1'b1; w_ctrl.gra = 1'b1; w_ctrl.rin = 1'b1; end
          C_ST:    w_ctrl.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    if (clear) w_ctrl = '0;
  end

  assign cu.PCout    = w_ctrl.pcout;
  assign cu.Zhighout = w_ctrl.zhighout;
  assign cu.Zlowout  = w_ctrl.zlowout;
  assign cu.MDRout   = w_ctrl.mdrout;
  assign cu.HIout    = w_ctrl.hiout;
  assign cu.LOout    = w_ctrl.loout;
  assign cu.Cout     = w_ctrl.cout;
  assign cu.MARin    = w_ctrl.marin;
  assign cu.Zin      = w_ctrl.zin;
  assign cu.PCin     = w_ctrl.pcin;
  assign cu.MDRin    = w_ctrl.mdrin;
  assign cu.IRin     = w_ctrl.irin;
  assign cu.Yin      = w_ctrl.yin;
  assign cu.HIin     = w_ctrl.hiin;
  assign cu.LOin     = w_ctrl.loin;
  assign cu.IncPC    = w_ctrl.incpc;
  assign cu.Read     = w_ctrl.read;
  assign cu.Write    = w_ctrl.write;
  assign cu.Gra      = w_ctrl.gra;
  assign cu.Grb      = w_ctrl.grb;
  assign cu.Grc      = w_ctrl.grc;
  assign cu.Rin      = w_ctrl.rin;
  assign cu.Rout     = w_ctrl.rout;
  assign cu.BAout    = w_ctrl.baout;
  assign cu.opcode   = w_ctrl.opcode;
  assign cu.Run      = (r_state != S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: each task walks one instruction class step by step
// and compares the full strobe/opcode/Run word against hand-derived expectations.
module tb_control_unit;

  logic clk = 1'b0;
  logic clear = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  control_unit_if u_if ();
  control_unit u_dut (.Clock(clk), .clear(clear), .cu(u_if));

  always #5 clk = ~clk;

  localparam logic [23:0] PCOUT = 24'd1 << 23, ZHIGHOUT = 24'd1 << 22, ZLOWOUT = 24'd1 << 21;
  localparam logic [23:0] MDROUT = 24'd1 << 20, HIOUT = 24'd1 << 19, LOOUT = 24'd1 << 18;
  localparam logic [23:0] COUT = 24'd1 << 17, MARIN = 24'd1 << 16, ZIN = 24'd1 << 15;
  localparam logic [23:0] PCIN = 24'd1 << 14, MDRIN = 24'd1 << 13, IRIN = 24'd1 << 12;
  localparam logic [23:0] YIN = 24'd1 << 11, HIIN = 24'd1 << 10, LOIN = 24'd1 << 9;
  localparam logic [23:0] INCPC = 24'd1 << 8, READ = 24'd1 << 7, WRITE = 24'd1 << 6;
  localparam logic [23:0] GRA = 24'd1 << 5, GRB = 24'd1 << 4, GRC = 24'd1 << 3;
  localparam logic [23:0] RIN = 24'd1 << 2, ROUT = 24'd1 << 1, BAOUT = 24'd1 << 0;

  localparam logic [29:0] IDLE_RUN = 30'b1;
  localparam logic [29:0] HALTED   = 30'b0;

  function automatic logic [29:0] obs();
    return {u_if.PCout, u_if.Zhighout, u_if.Zlowout, u_if.MDRout, u_if.HIout, u_if.LOout,
            u_if.Cout, u_if.MARin, u_if.Zin, u_if.PCin, u_if.MDRin, u_if.IRin, u_if.Yin,
            u_if.HIin, u_if.LOin, u_if.IncPC, u_if.Read, u_if.Write, u_if.Gra, u_if.Grb,
            u_if.Grc, u_if.Rin, u_if.Rout, u_if.BAout, u_if.opcode, u_if.Run};
  endfunction

  function automatic logic [29:0] mk(input logic [23:0] s, input logic [4:0] op);
    return {s, op, 1'b1};
  endfunction

  function automatic logic [29:0] f0();
    return mk(PCOUT | MARIN | INCPC | ZIN, 5'b0);
  endfunction
  function automatic logic [29:0] f1();
    return mk(ZLOWOUT | PCIN | READ | MDRIN, 5'b0);
  endfunction
  function automatic logic [29:0] f2();
    return mk(MDROUT | IRIN, 5'b0);
  endfunction

  task automatic test_reset();
    clear = 1'b1;
    u_if.IR = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if (obs() !== IDLE_RUN) $display("FAIL reset_held: got %h expected %h", obs(), IDLE_RUN);
    else n_pass++;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    n_total++;
    if (obs() !== f0()) $display("FAIL reset_t0: got %h expected %h", obs(), f0());
    else n_pass++;
  endtask

  // Each instruction task pulses clear to land on T0, then checks e[0..n-1] one per cycle.
  task automatic test_alu_and();
    logic [29:0] e [7];
    e = '{f0(), f1(), f2(), mk(GRB | ROUT | YIN, 5'b0), mk(GRC | ROUT | ZIN, 5'b00101),
          mk(ZLOWOUT | GRA | RIN, 5'b0), f0()};
    clear = 1'b1; u_if.IR = 32'h28918000; @(posedge clk); #1; clear = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_total++;
      if (obs() !== e[i]) $display("FAIL and step %0d: got %h expected %h", i, obs(), e[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load();
    logic [29:0] e [9];
    e = '{f0(), f1(), f2(), mk(GRB | BAOUT | YIN, 5'b0), mk(COUT | ZIN, 5'b00011),
          mk(ZLOWOUT | MARIN, 5'b0), mk(READ | MDRIN, 5'b0), mk(MDROUT | GRA | RIN, 5'b0), f0()};
    clear = 1'b1; u_if.IR = 32'h00800055; @(posedge clk); #1; clear = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      n_total++;
      if (obs() !== e[i]) $display("FAIL ld step %0d: got %h expected %h", i, obs(), e[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul();
    logic [29:0] e [8];
    e = '{f0(), f1(), f2(), mk(GRA | ROUT | YIN, 5'b0), mk(GRB | ROUT | ZIN, 5'b01111),
          mk(ZLOWOUT | LOIN, 5'b0), mk(ZHIGHOUT | HIIN, 5'b0), f0()};
    clear = 1'b1; u_if.IR = {5'b01111, 27'h0123456}; @(posedge clk); #1; clear = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_total++;
      if (obs() !== e[i]) $display("FAIL mul step %0d: got %h expected %h", i, obs(), e[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_ldi();
    logic [29:0] e [9];
    logic [31:0] ir;
    int n;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        ir = {5'b00010, 27'h0400010};
        n = 9;
        e = '{f0(), f1(), f2(), mk(GRB | BAOUT | YIN, 5'b0), mk(COUT | ZIN, 5'b00011),
              mk(ZLOWOUT | MARIN, 5'b0), mk(GRA | ROUT | MDRIN, 5'b0), mk(WRITE, 5'b0), f0()};
      end else begin
        ir = {5'b00001, 27'h0000007};
        n = 7;
        e = '{f0(), f1(), f2(), mk(GRB | BAOUT | YIN, 5'b0), mk(COUT | ZIN, 5'b00011),
              mk(ZLOWOUT | GRA | RIN, 5'b0), f0(), 30'b0, 30'b0};
      end
      clear = 1'b1; u_if.IR = ir; @(posedge clk); #1; clear = 1'b0;
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        n_total++;
        if (obs() !== e[i]) $display("FAIL st_ldi %0d step %0d: got %h expected %h", k, i, obs(), e[i]);
        else n_pass++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_imm_unary();
    logic [29:0] e [7];
    logic [31:0] ir;
    int n;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        ir = {5'b01110, 27'h0000ABC};
        n = 7;
        e = '{f0(), f1(), f2(), mk(GRB | ROUT | YIN, 5'b0), mk(COUT | ZIN, 5'b00110),
              mk(ZLOWOUT | GRA | RIN, 5'b0), f0()};
      end else begin
        ir = {5'b10001, 27'h0880000};
        n = 6;
        e = '{f0(), f1(), f2(), mk(GRB | ROUT | ZIN, 5'b10001), mk(ZLOWOUT | GRA | RIN, 5'b0),
              f0(), 30'b0};
      end
      clear = 1'b1; u_if.IR = ir; @(posedge clk); #1; clear = 1'b0;
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        n_total++;
        if (obs() !== e[i]) $display("FAIL imm_unary %0d step %0d: got %h expected %h", k, i, obs(), e[i]);
        else n_pass++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_nop();
    logic [29:0] e [4];
    e = '{f0(), f1(), f2(), f0()};
    for (int k = 0; k < 2; k++) begin
      clear = 1'b1;
      u_if.IR = (k == 0) ? {5'b11010, 27'h0} : {5'b11111, 27'h7FFFFFF};
      @(posedge clk); #1; clear = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        n_total++;
        if (obs() !== e[i]) $display("FAIL nop %0d step %0d: got %h expected %h", k, i, obs(), e[i]);
        else n_pass++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_halt();
    logic [29:0] e [3];
    e = '{f0(), f1(), f2()};
    clear = 1'b1; u_if.IR = {5'b11011, 27'h0}; @(posedge clk); #1; clear = 1'b0;
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      n_total++;
      if (obs() !== ((i < 3) ? e[i] : HALTED))
        $display("FAIL halt cycle %0d: got %h expected %h", i, obs(), (i < 3) ? e[i] : HALTED);
      else n_pass++;
      @(posedge clk); #1;
    end
    clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
    @(negedge clk);
    n_total++;
    if (obs() !== f0()) $display("FAIL halt_exit: got %h expected %h", obs(), f0());
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    logic [29:0] e [4];
    e = '{f0(), f1(), f2(), mk(GRB | ROUT | YIN, 5'b0)};
    clear = 1'b1; u_if.IR = {5'b00011, 27'h0918000}; @(posedge clk); #1; clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_total++;
      if (obs() !== e[i]) $display("FAIL abort step %0d: got %h expected %h", i, obs(), e[i]);
      else n_pass++;
      @(posedge clk); #1;
    end
    clear = 1'b1;
    @(negedge clk);
    n_total++;
    if (obs() !== IDLE_RUN) $display("FAIL abort_t4_quiet: got %h expected %h", obs(), IDLE_RUN);
    else n_pass++;
    @(posedge clk); #1; clear = 1'b0;
    @(negedge clk);
    n_total++;
    if (obs() !== f0()) $display("FAIL abort_refetch: got %h expected %h", obs(), f0());
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if (obs() !== f1()) $display("FAIL abort_t1: got %h expected %h", obs(), f1());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu_and();
    test_load();
    test_mul();
    test_store_ldi();
    test_imm_unary();
    test_nop();
    test_halt();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
